javk_membus: RTL and testbench
==============================

// Module: javk_membus
// PURPOSE
//   Bus interface unit directly downstream of the JAVK CPU core's 16-bit address / 8-bit data bus.
//   - Accepts one byte read or write per request.
//   - Decodes the I/O page (address high byte == IO_PAGE) vs. memory.
//   - Drives a synchronous SRAM with a programmable wait-state count.
//   - Runs an ack-handshaked I/O port with a timeout.
//   - Returns read data and a one-cycle ready pulse so the core can stall.
// PARAMETERS
//   WAIT_STATES  2      extra SRAM cycles per access (0..15)
//   IO_PAGE      8'hFF  addr[15:8] value that selects the I/O port instead of SRAM
//   IO_TIMEOUT   15     max cycles io_stb is held waiting for io_ack (1..255)
// PORTS
//   clk        in   1   system clock; all state changes on posedge
//   rst        in   1   asynchronous, active-high reset
//   cpu_req    in   1   request strobe; sampled only when busy==0
//   cpu_rw     in   1   1=write, 0=read (same polarity as core rw)
//   cpu_addr   in   16  byte address
//   cpu_wdata  in   8   write data
//   cpu_rdata  out  8   read data; valid in ready cycle, held until next read completes
//   cpu_ready  out  1   one-cycle pulse: transaction complete
//   cpu_err    out  1   with cpu_ready: I/O timeout occurred
//   busy       out  1   high whenever state != IDLE
//   mem_ce     out  1   SRAM chip enable
//   mem_we     out  1   SRAM write enable (only with mem_ce)
//   mem_addr   out  16  SRAM address
//   mem_wdata  out  8   SRAM write data
//   mem_rdata  in   8   SRAM read data, valid by last wait cycle
//   io_stb     out  1   I/O strobe, held until io_ack or timeout
//   io_we      out  1   I/O write qualifier
//   io_addr    out  8   addr[7:0] of the I/O access
//   io_wdata   out  8   I/O write data
//   io_rdata   in   8   I/O read data, valid with io_ack
//   io_ack     in   1   I/O completion
// BEHAVIOUR
//   Reset (async, any state): state=IDLE. Every output and internal register is 0: counters, cpu_rdata, mem_*/io_* outputs.
//   FSM states: IDLE, MEM_WAIT, IO_WAIT, DONE. All outputs are registered.
//   IDLE:
//     - busy=0. On cpu_req=1, latch rw/addr/wdata.
//     - If addr[15:8]==IO_PAGE: go to IO_WAIT; io_stb=1, io_we=rw, io_addr, io_wdata; tmo=IO_TIMEOUT.
//     - Else: go to MEM_WAIT; mem_ce=1, mem_we=rw, mem_addr, mem_wdata; cnt=WAIT_STATES.
//   MEM_WAIT:
//     - If cnt!=0: cnt<=cnt-1.
//     - Else: go to DONE; drop mem_ce/mem_we; read captures mem_rdata into cpu_rdata.
//   IO_WAIT:
//     - io_ack=1: go to DONE; drop io_stb/io_we; read captures io_rdata.
//     - Else if tmo==1: go to DONE; drop io_stb; cpu_err=1; read returns 8'hFF.
//     - Else: tmo<=tmo-1.
//     - io_ack and timeout on the same edge: ack wins, no error.
//   DONE: cpu_ready=1 for exactly this cycle; next edge returns to IDLE, clears ready and err.
//   Latency, from the edge sampling cpu_req to cpu_ready high:
//     - memory: WAIT_STATES+2 cycles (W=0 gives 2).
//     - I/O: k+1 cycles when io_ack is seen at the k-th IO_WAIT edge.
//     - I/O timeout: IO_TIMEOUT+1 cycles.
//   Write transactions leave cpu_rdata unchanged.
//   cpu_req while busy=1 is ignored; it is not queued.
//   The core must drop cpu_req during the ready cycle, otherwise a new transaction starts on the next IDLE edge.
//   Address range: 16'h0000..16'hFEFF is SRAM (with the default IO_PAGE); 16'hFF00..16'hFFFF is I/O.
//   No wrap or increment is performed; the address passes through unchanged.
//   io_ack outside IO_WAIT is ignored.
// TESTING
//   1. W=2, write 8'hA5 @16'h1234, then read @16'h1234:
//      mem_ce high 3 cycles each; ready 4 cycles after req; cpu_rdata=8'hA5, err=0.
//   2. W=0, back-to-back reads @16'h0000 and @16'hFEFF:
//      ready 2 cycles after each req; busy low exactly one cycle between transactions.
//   3. Read @16'hFF10, io_ack with io_rdata=8'h3C on the 3rd IO_WAIT edge:
//      io_addr=8'h10; ready 4 cycles after req; cpu_rdata=8'h3C; err=0.
//   4. Write @16'hFF01, io_ack never asserted:
//      io_stb held IO_TIMEOUT cycles; ready with err=1; cpu_rdata unchanged.
//   5. Read in progress (MEM_WAIT, cnt=1), assert rst mid-cycle:
//      immediately state=IDLE and mem_ce=busy=cpu_ready=0 with no clock edge; cpu_rdata=0.
//   6. Pulse cpu_req while busy, and pulse io_ack during IDLE:
//      no extra transaction, no ready pulse, outputs unchanged.

Source files
------------

// File: rtl/javk_membus.sv
// JAVK bus interface unit: one byte per request, routed to SRAM or the I/O page.
// SRAM accesses take a fixed wait-state count; I/O accesses wait for ack or time out.
module javk_membus #(
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [7:0]  IO_PAGE     = 8'hFF,
  parameter int unsigned IO_TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_err,
  output logic        busy,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        io_stb,
  output logic        io_we,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_wdata,
  input  logic [7:0]  io_rdata,
  input  logic        io_ack
);

  localparam logic [3:0] WS  = 4'(WAIT_STATES);
  localparam logic [7:0] TMO = 8'(IO_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    MEM_WAIT,
    IO_WAIT,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        rw_q, rw_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        mce_q, mce_d;
  logic        mwe_q, mwe_d;
  logic [15:0] maddr_q, maddr_d;
  logic [7:0]  mwdata_q, mwdata_d;
  logic        stb_q, stb_d;
  logic        iowe_q, iowe_d;
  logic [7:0]  ioaddr_q, ioaddr_d;
  logic [7:0]  iowdata_q, iowdata_d;

  // Next-state and next-output computation for the access sequencer
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    rw_d      = rw_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    busy_d    = busy_q;
    mce_d     = mce_q;
    mwe_d     = mwe_q;
    maddr_d   = maddr_q;
    mwdata_d  = mwdata_q;
    stb_d     = stb_q;
    iowe_d    = iowe_q;
    ioaddr_d  = ioaddr_q;
    iowdata_d = iowdata_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          rw_d   = cpu_rw;
          busy_d = 1'b1;
          if (cpu_addr[15:8] == IO_PAGE) begin
            state_d   = IO_WAIT;
            stb_d     = 1'b1;
            iowe_d    = cpu_rw;
            ioaddr_d  = cpu_addr[7:0];
            iowdata_d = cpu_wdata;
            tmo_d     = TMO;
          end else begin
            state_d  = MEM_WAIT;
            mce_d    = 1'b1;
            mwe_d    = cpu_rw;
            maddr_d  = cpu_addr;
            mwdata_d = cpu_wdata;
            cnt_d    = WS;
          end
        end
      end
      MEM_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
          mce_d   = 1'b0;
          mwe_d   = 1'b0;
          ready_d = 1'b1;
          if (!rw_q) rdata_d = mem_rdata;
        end
      end
      IO_WAIT: begin
        // ack takes priority over a timeout landing on the same edge
        if (io_ack) begin
          state_d = DONE;
          stb_d   = 1'b0;
          iowe_d  = 1'b0;
          ready_d = 1'b1;
          if (!rw_q) rdata_d = io_rdata;
        end else if (tmo_q == 8'd1) begin
          state_d = DONE;
          stb_d   = 1'b0;
          iowe_d  = 1'b0;
          ready_d = 1'b1;
          err_d   = 1'b1;
          if (!rw_q) rdata_d = 8'hFF;
        end else begin
          tmo_d = tmo_q - 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Register state and every output; async reset clears everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      rw_q      <= 1'b0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      mce_q     <= 1'b0;
      mwe_q     <= 1'b0;
      maddr_q   <= '0;
      mwdata_q  <= '0;
      stb_q     <= 1'b0;
      iowe_q    <= 1'b0;
      ioaddr_q  <= '0;
      iowdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      rw_q      <= rw_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      mce_q     <= mce_d;
      mwe_q     <= mwe_d;
      maddr_q   <= maddr_d;
      mwdata_q  <= mwdata_d;
      stb_q     <= stb_d;
      iowe_q    <= iowe_d;
      ioaddr_q  <= ioaddr_d;
      iowdata_q <= iowdata_d;
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_ready = ready_q;
  assign cpu_err   = err_q;
  assign busy      = busy_q;
  assign mem_ce    = mce_q;
  assign mem_we    = mwe_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwdata_q;
  assign io_stb    = stb_q;
  assign io_we     = iowe_q;
  assign io_addr   = ioaddr_q;
  assign io_wdata  = iowdata_q;

endmodule

// File: tb/tb_javk_membus.sv
// Bench for javk_membus: vector table, corner sequences, random traffic vs model.
// Instance a uses default wait states, instance b uses zero wait states.
module tb_javk_membus;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cpu_req = 1'b0;
  logic        cpu_rw = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  io_rdata = '0;
  logic        io_ack = 1'b0;
  logic        sel = 1'b0;

  logic [7:0]  rdata_a, mwdata_a, ioaddr_a, iowdata_a;
  logic        ready_a, err_a, busy_a, mce_a, mwe_a, stb_a, iowe_a;
  logic [15:0] maddr_a;
  logic [7:0]  rdata_b, mwdata_b, ioaddr_b, iowdata_b;
  logic        ready_b, err_b, busy_b, mce_b, mwe_b, stb_b, iowe_b;
  logic [15:0] maddr_b;

  logic [7:0] sram [0:65535];
  logic [7:0] shadow [0:65535];
  wire  [7:0] mrd_a = sram[maddr_a];
  wire  [7:0] mrd_b = sram[maddr_b];
  wire        req_a = cpu_req & ~sel;
  wire        req_b = cpu_req & sel;

  always @(posedge clk) begin
    if (mce_a && mwe_a) sram[maddr_a] <= mwdata_a;
    if (mce_b && mwe_b) sram[maddr_b] <= mwdata_b;
  end

  javk_membus u_a (
    .clk(clk), .rst(rst), .cpu_req(req_a), .cpu_rw(cpu_rw),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(rdata_a),
    .cpu_ready(ready_a), .cpu_err(err_a), .busy(busy_a),
    .mem_ce(mce_a), .mem_we(mwe_a), .mem_addr(maddr_a),
    .mem_wdata(mwdata_a), .mem_rdata(mrd_a), .io_stb(stb_a),
    .io_we(iowe_a), .io_addr(ioaddr_a), .io_wdata(iowdata_a),
    .io_rdata(io_rdata), .io_ack(io_ack)
  );

  javk_membus #(.WAIT_STATES(0)) u_b (
    .clk(clk), .rst(rst), .cpu_req(req_b), .cpu_rw(cpu_rw),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(rdata_b),
    .cpu_ready(ready_b), .cpu_err(err_b), .busy(busy_b),
    .mem_ce(mce_b), .mem_we(mwe_b), .mem_addr(maddr_b),
    .mem_wdata(mwdata_b), .mem_rdata(mrd_b), .io_stb(stb_b),
    .io_we(iowe_b), .io_addr(ioaddr_b), .io_wdata(iowdata_b),
    .io_rdata(io_rdata), .io_ack(io_ack)
  );

  wire        v_ready = sel ? ready_b : ready_a;
  wire        v_err   = sel ? err_b : err_a;
  wire [7:0]  v_rdata = sel ? rdata_b : rdata_a;
  wire        v_mce   = sel ? mce_b : mce_a;
  wire        v_mwe   = sel ? mwe_b : mwe_a;
  wire [15:0] v_maddr = sel ? maddr_b : maddr_a;
  wire        v_stb   = sel ? stb_b : stb_a;
  wire        v_iowe  = sel ? iowe_b : iowe_a;
  wire [7:0]  v_ioadr = sel ? ioaddr_b : ioaddr_a;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  int          t_lat, t_ce, t_stb;
  logic [7:0]  t_rd;
  logic        t_err, t_seen, t_we;
  logic [15:0] t_oa;

  // One transaction: req at a negedge, ack shown at the k-th wait edge
  task automatic run_txn(input logic rw, input logic [15:0] a,
                         input logic [7:0] wd, input int k,
                         input logic [7:0] ad);
    int n;
    @(negedge clk);
    cpu_req = 1'b1; cpu_rw = rw; cpu_addr = a; cpu_wdata = wd;
    io_ack = 1'b0; io_rdata = ad;
    n = 0; t_seen = 1'b0; t_ce = 0; t_stb = 0;
    t_oa = '0; t_we = 1'b0;
    while (n < 40 && !t_seen) begin
      io_ack = (k != 0 && n == k);
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) begin
        cpu_req = 1'b0;
        t_oa = v_stb ? {8'h00, v_ioadr} : v_maddr;
        t_we = v_stb ? v_iowe : v_mwe;
      end
      if (v_mce) t_ce++;
      if (v_stb) t_stb++;
      if (v_ready) t_seen = 1'b1;
    end
    io_ack = 1'b0;
    t_lat = n; t_rd = v_rdata; t_err = v_err;
  endtask

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  wd;
    int          k;
    logic [7:0]  ad;
    int          lat;
    logic [7:0]  rd;
    logic        err;
    int          ce;
    int          stb;
    logic [15:0] oa;
  } vec_t;

  vec_t tbl [8];

  logic [15:0] pool [5];
  logic [7:0]  model_rd;
  int          rb [8];
  int          rdy_cnt, busy_hi;
  logic [7:0]  rd_b [8];

  initial begin
    for (int i = 0; i < 65536; i++) begin
      sram[i] = 8'h00;
      shadow[i] = 8'h00;
    end
    sram[0] = 8'h11;
    shadow[0] = 8'h11;

    tbl[0] = '{1'b1, 16'h1234, 8'hA5, 0, 8'h00, 4, 8'h00, 1'b0, 3, 0, 16'h1234};
    tbl[1] = '{1'b0, 16'h1234, 8'h00, 0, 8'h00, 4, 8'hA5, 1'b0, 3, 0, 16'h1234};
    tbl[2] = '{1'b0, 16'hFF10, 8'h00, 3, 8'h3C, 4, 8'h3C, 1'b0, 0, 3, 16'h0010};
    tbl[3] = '{1'b1, 16'hFF01, 8'h99, 0, 8'h00, 16, 8'h3C, 1'b1, 0, 15, 16'h0001};
    tbl[4] = '{1'b0, 16'hFF01, 8'h00, 0, 8'h00, 16, 8'hFF, 1'b1, 0, 15, 16'h0001};
    tbl[5] = '{1'b0, 16'hFFFF, 8'h00, 1, 8'h5A, 2, 8'h5A, 1'b0, 0, 1, 16'h00FF};
    tbl[6] = '{1'b1, 16'hFEFF, 8'h77, 0, 8'h00, 4, 8'h5A, 1'b0, 3, 0, 16'hFEFF};
    tbl[7] = '{1'b0, 16'hFEFF, 8'h00, 0, 8'h00, 4, 8'h77, 1'b0, 3, 0, 16'hFEFF};

    // reset state
    #12;
    check("rst_outs_a",
          {rdata_a, ready_a, err_a, busy_a, mce_a, mwe_a, stb_a, iowe_a},
          32'h0);
    check("rst_bus_a", {maddr_a, mwdata_a, ioaddr_a}, 32'h0);
    check("rst_iowd_a", {24'h0, iowdata_a}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // vector table on the default-wait instance
    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].rw, tbl[i].addr, tbl[i].wd, tbl[i].k, tbl[i].ad);
      check($sformatf("v%0d_seen", i), {31'h0, t_seen}, 32'h1);
      check($sformatf("v%0d_lat", i), t_lat, tbl[i].lat);
      check($sformatf("v%0d_rd", i), {24'h0, t_rd}, {24'h0, tbl[i].rd});
      check($sformatf("v%0d_err", i), {31'h0, t_err}, {31'h0, tbl[i].err});
      check($sformatf("v%0d_ce", i), t_ce, tbl[i].ce);
      check($sformatf("v%0d_stb", i), t_stb, tbl[i].stb);
      check($sformatf("v%0d_oa", i), {16'h0, t_oa}, {16'h0, tbl[i].oa});
      check($sformatf("v%0d_we", i), {31'h0, t_we}, {31'h0, tbl[i].rw});
    end
    shadow[16'h1234] = 8'hA5;
    shadow[16'hFEFF] = 8'h77;
    model_rd = 8'h77;

    // back-to-back reads on the zero-wait instance, req held high
    @(negedge clk);
    sel = 1'b1;
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h0000;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk);
      @(negedge clk);
      rb[n] = {30'h0, busy_b, ready_b};
      rd_b[n] = rdata_b;
      if (ready_b) cpu_addr = 16'hFEFF;
      if (n == 5) cpu_req = 1'b0;
    end
    for (int n = 1; n <= 5; n++) begin
      check($sformatf("b2b_rdy%0d", n), {31'h0, rb[n][0]},
            (n == 2 || n == 5) ? 32'h1 : 32'h0);
      check($sformatf("b2b_busy%0d", n), {31'h0, rb[n][1]},
            (n == 3) ? 32'h0 : 32'h1);
    end
    check("b2b_rd0", {24'h0, rd_b[2]}, 32'h11);
    check("b2b_rd1", {24'h0, rd_b[5]}, 32'h77);
    @(negedge clk);
    sel = 1'b0;

    // req pulse while busy, then io_ack pulse while idle
    @(negedge clk);
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h1234;
    rdy_cnt = 0; busy_hi = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      @(negedge clk);
      cpu_req = (n == 2);
      if (n == 2) cpu_addr = 16'hFF20;
      if (ready_a) rdy_cnt++;
      if (stb_a) busy_hi++;
    end
    cpu_req = 1'b0;
    check("busy_req_rdy", rdy_cnt, 1);
    check("busy_req_nostb", busy_hi, 0);
    check("busy_req_rd", {24'h0, rdata_a}, 32'hA5);
    rdy_cnt = 0; busy_hi = 0;
    io_ack = 1'b1; io_rdata = 8'hC3;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 2) io_ack = 1'b0;
      if (ready_a) rdy_cnt++;
      if (busy_a || stb_a || mce_a) busy_hi++;
    end
    check("idle_ack_rdy", rdy_cnt, 0);
    check("idle_ack_busy", busy_hi, 0);
    check("idle_ack_rd", {24'h0, rdata_a}, 32'hA5);

    // async reset in MEM_WAIT with cnt=1
    @(negedge clk);
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h0100;
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_pre", {30'h0, busy_a, mce_a}, 32'h3);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ctl", {29'h0, busy_a, mce_a, ready_a}, 32'h0);
    check("mid_rst_rd", {24'h0, rdata_a}, 32'h0);
    #1 rst = 1'b0;
    model_rd = 8'h00;

    // random traffic against the behavioural model
    pool[0] = 16'h0010; pool[1] = 16'h0011; pool[2] = 16'h1234;
    pool[3] = 16'h8000; pool[4] = 16'hFEFE;
    for (int i = 0; i < 80; i++) begin
      logic        rw, io;
      logic [15:0] a;
      logic [7:0]  wd, ad;
      int          k, el;
      logic        ee;
      rw = 1'($urandom_range(0, 1));
      io = ($urandom_range(0, 2) == 0);
      wd = 8'($urandom);
      ad = 8'($urandom);
      k  = io ? int'($urandom_range(1, 18)) : 0;
      a  = io ? {8'hFF, 8'($urandom)} : pool[$urandom_range(0, 4)];
      ee = 1'b0;
      if (!io) begin
        el = 4;
        if (rw) shadow[a] = wd;
        else model_rd = shadow[a];
      end else if (k <= 15) begin
        el = k + 1;
        if (!rw) model_rd = ad;
      end else begin
        el = 16;
        ee = 1'b1;
        if (!rw) model_rd = 8'hFF;
      end
      run_txn(rw, a, wd, k, ad);
      check($sformatf("r%0d_seen", i), {31'h0, t_seen}, 32'h1);
      check($sformatf("r%0d_lat", i), t_lat, el);
      check($sformatf("r%0d_rd", i), {24'h0, t_rd}, {24'h0, model_rd});
      check($sformatf("r%0d_err", i), {31'h0, t_err}, {31'h0, ee});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
